// File: rtl/ram_dp_be.sv
// rtl/ram_dp_be.sv - simple-dual-port byte-enable RAM with reset-driven zero-fill sequencer
module ram_dp_be #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_enable,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_enable,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_width_check
        $error("ram_dp_be: DATA_WIDTH must be a non-zero multiple of 8");
    end

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_be;
    logic [DATA_WIDTH-1:0]   rd_old;
    logic [DATA_WIDTH-1:0]   rd_merged;

    assign rd_old = mem_q[rd_addr];

    // Write-through view of the read word: enabled lanes come from the incoming write.
    always_comb begin
        rd_merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                rd_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        mem_be     = wr_be;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                cnt_d     = cnt_q + ADDR_WIDTH'(1);
                rd_data_d = '0;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                mem_we = wr_enable;
                if (rd_enable) begin
                    rd_valid_d = 1'b1;
                    if (RDW_MODE == 1 && wr_enable && wr_addr == rd_addr) begin
                        rd_data_d = rd_merged;
                    end else begin
                        rd_data_d = rd_old;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage has no reset of its own; the sequencer is the only way to zero it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_busy = (state_q == S_CLEAR);
endmodule

// File: tb/tb_ram_dp_be.sv
// tb/tb_ram_dp_be.sv - directed and table-driven bench for ram_dp_be in both read-during-write modes
module tb_ram_dp_be;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_enable;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_enable;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data0, rd_data1;
    logic        rd_valid0, rd_valid1;
    logic        busy0, busy1;

    int checks = 0;
    int errors = 0;
    logic [15:0] model [16];

    always #5 clk = ~clk;

    ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_dut0 (
        .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .init_busy(busy0)
    );

    ram_dp_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .rst(rst), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_enable(rd_enable), .rd_addr(rd_addr), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .init_busy(busy1)
    );

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        cd;
        logic        ev;
        logic [15:0] ed0;
        logic [15:0] ed1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_enable = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_enable = 1'b0; rd_addr = '0;
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [1:0] be, input logic re, input logic [3:0] ra);
        wr_enable = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_enable = re; rd_addr = ra;
        @(posedge clk);
        if (we) begin
            if (be[0]) model[wa][7:0]  = wd[7:0];
            if (be[1]) model[wa][15:8] = wd[15:8];
        end
        #1;
        idle_inputs();
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy0 && n < 40);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 16; i++) model[i] = '0;
    endtask

    initial begin
        int n;
        logic [3:0]  ra;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;

        vecs[0]  = '{1'b1, 4'd3, 16'hA5C3, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0,    16'h0};
        vecs[1]  = '{1'b1, 4'd3, 16'h1234, 2'b01, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0,    16'h0};
        vecs[2]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 16'hA534, 16'hA534};
        vecs[3]  = '{1'b1, 4'd3, 16'hFFFF, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 16'hA534, 16'hA534};
        vecs[4]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd3, 1'b1, 1'b1, 16'hA534, 16'hA534};
        vecs[5]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0,    16'h0};
        vecs[6]  = '{1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 1'b1, 1'b1, 16'h1111, 16'h2222};
        vecs[7]  = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 1'b1, 16'h2222, 16'h2222};
        vecs[8]  = '{1'b1, 4'd5, 16'h1111, 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0,    16'h0};
        vecs[9]  = '{1'b1, 4'd5, 16'h2222, 2'b10, 1'b1, 4'd5, 1'b1, 1'b1, 16'h1111, 16'h2211};
        vecs[10] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd5, 1'b1, 1'b1, 16'h2211, 16'h2211};
        vecs[11] = '{1'b1, 4'd6, 16'hABCD, 2'b11, 1'b1, 4'd3, 1'b1, 1'b1, 16'hA534, 16'hA534};
        vecs[12] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 4'd6, 1'b1, 1'b1, 16'hABCD, 16'hABCD};
        vecs[13] = '{1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd6, 1'b1, 1'b0, 16'hABCD, 16'hABCD};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_valid", {15'd0, rd_valid0}, 16'd0);
        chk("reset rd_data", rd_data0, 16'h0000);
        chk("reset init_busy", {15'd0, busy0}, 16'd1);
        rst = 1'b0;
        wait_clear(n);
        chk("first clear length", 16'(n), 16'd16);
        chk("busy1 low", {15'd0, busy1}, 16'd0);
        model_zero();

        for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 16'hFFFF, 2'b11, 1'b0, 4'd0);
        step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd9);
        chk("prefill readback", rd_data0, 16'hFFFF);

        // Requests held high throughout the clear must be ignored.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst pulse busy", {15'd0, busy0}, 16'd1);
        wr_enable = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
        rd_enable = 1'b1; rd_addr = 4'd7;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            chk("clear rd_valid", {15'd0, rd_valid0 | rd_valid1}, 16'd0);
            chk("clear rd_data", rd_data0 | rd_data1, 16'h0000);
        end while (busy0 && n < 40);
        idle_inputs();
        chk("clear with requests length", 16'(n), 16'd16);
        model_zero();

        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'(i));
            chk("post clear valid", {15'd0, rd_valid0 & rd_valid1}, 16'd1);
            chk("post clear data", rd_data0 | rd_data1, 16'h0000);
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid clear busy", {15'd0, busy0}, 16'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_clear(n);
        chk("restarted clear length", 16'(n), 16'd16);
        model_zero();

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].re, vecs[i].ra);
            chk($sformatf("vec%0d valid0", i), {15'd0, rd_valid0}, {15'd0, vecs[i].ev});
            chk($sformatf("vec%0d valid1", i), {15'd0, rd_valid1}, {15'd0, vecs[i].ev});
            if (vecs[i].cd) begin
                chk($sformatf("vec%0d data0", i), rd_data0, vecs[i].ed0);
                chk($sformatf("vec%0d data1", i), rd_data1, vecs[i].ed1);
            end
        end

        for (int i = 0; i < 20; i++) begin
            wa = 4'($urandom_range(0, 15));
            wd = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            step(1'b1, wa, wd, be, 1'b0, 4'd0);
        end
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            wr_enable = 1'b0;
            rd_enable = 1'b1; rd_addr = ra;
            @(posedge clk);
            #1;
            chk($sformatf("rand%0d valid", i), {15'd0, rd_valid0 & rd_valid1}, 16'd1);
            chk($sformatf("rand%0d data0", i), rd_data0, model[ra]);
            chk($sformatf("rand%0d data1", i), rd_data1, model[ra]);
        end
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rand idle valid", {15'd0, rd_valid0}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_dp_be.md
Name: ram_dp_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port, one read port, one clock. It generalises the 16x8 RAM to arbitrary width and depth, with per-byte write enables and a selectable read-during-write mode. A reset-driven clear sequencer zeroes every location one word per cycle. It is the common storage primitive for buffers and register files in the datapath.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8 (elaboration error otherwise)
ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH words
RDW_MODE, 0, same-address read-during-write: 0 = read-old, 1 = write-through
CLEAR_ON_RESET, 1, 1 = sequential zero-fill after reset; 0 = memory contents retained across reset

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
wr_enable  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_be  input  DATA_WIDTH/8  byte-lane enables; bit i enables wr_data[8i+7:8i]
rd_enable  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_data  output  DATA_WIDTH  registered read data
rd_valid  output  1  rd_data updated at this edge
init_busy  output  1  clear sequence in progress; requests are ignored

Behaviour:
- Reset: on any posedge with rst=1, the block forces rd_data=0, rd_valid=0, clear counter=0.
  - If CLEAR_ON_RESET=1: state=CLEAR and init_busy=1.
  - If CLEAR_ON_RESET=0: state=IDLE and init_busy=0.
  - rst takes priority over all requests.
- State machine: states CLEAR and IDLE.
- CLEAR, rst=0: each posedge writes mem[cnt]=0 and increments cnt.
  - At the posedge that clears address DEPTH-1, the block goes to IDLE and sets init_busy=0.
  - init_busy therefore falls exactly DEPTH posedges after the first posedge with rst low.
- CLEAR, requests: wr_enable and rd_enable are ignored. No memory update from the ports, rd_valid=0, rd_data holds 0.
- Reset mid-clear: rst=1 during CLEAR restarts the sequence at address 0.
- Reset mid-operation in IDLE: any request at the rst edge is dropped.
- Write (IDLE): at a posedge with wr_enable=1, mem[wr_addr] lane i takes wr_data lane i for each wr_be[i]=1. Lanes with wr_be[i]=0 are unchanged. wr_be=0 leaves the word unchanged.
- Read (IDLE): at a posedge with rd_enable=1, rd_data takes mem[rd_addr] and rd_valid=1 for the following cycle. Latency is 1 cycle from request edge to data.
- No read: with rd_enable=0, rd_valid=0 and rd_data holds its last value.
- Simultaneous read and write, different addresses: fully independent; both complete in the same cycle.
- Simultaneous read and write, same address:
  - RDW_MODE=0: rd_data = pre-write word.
  - RDW_MODE=1: rd_data = merged word (enabled lanes from wr_data, other lanes from the old word).
  - Memory is updated identically in both modes.
- Addresses: always in range (full ADDR_WIDTH decode), so there is no wrap or aliasing logic. Back-to-back writes/reads every cycle are supported with no bubbles.
- Power-up: memory is X until the first reset clear. With CLEAR_ON_RESET=0 it stays X until written.

Test Plan:
- DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_ON_RESET=1. Write 0xFFFF to all 16 addresses; pulse rst for 1 cycle; read addresses 0..15 after init_busy falls -> init_busy high for exactly 16 cycles after rst low; every read returns 0x0000 with rd_valid=1 one cycle after request.
- Byte lanes. Write addr 3 = 0xA5C3 with wr_be=2'b11; write addr 3 = 0x1234 with wr_be=2'b01; read addr 3 -> rd_data=0xA534. Write with wr_be=2'b00 -> addr 3 still reads 0xA534.
- RDW_MODE=0. addr 5 holds 0x1111; same-cycle write 0x2222 (be=11) and read of addr 5 -> rd_data=0x1111; next-cycle read -> 0x2222.
- RDW_MODE=1. Same stimulus with a be=10 write of 0x2222 -> rd_data=0x2211; memory holds 0x2211.
- Reset and requests during CLEAR.
  - Assert wr_enable (addr 7 = 0xBEEF) and rd_enable while init_busy=1 -> rd_valid stays 0; addr 7 reads 0x0000 after clear.
  - Re-assert rst at clear cycle 8 -> init_busy stays high a further 16 cycles after rst low.
- 20 random back-to-back writes then 20 random reads vs. a byte-enable-aware reference model -> zero mismatches, rd_valid high on each of the 20 read-response cycles.
